// File: rtl/inst_sram_resp_pkg.sv
// Shared widths, the default window base and the access decode for the SRAM responder.
// Consumers: inst_sram_resp_if, sram_byte_lane, inst_sram_resp.
package inst_sram_resp_pkg;

  localparam int SRAM_AW   = 32;
  localparam int SRAM_DW   = 32;
  localparam int SRAM_BE_W = 4;
  localparam logic [SRAM_AW-1:0] SRAM_BASE = 32'h1c000000;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } acc_kind_e;

  // Offset is compared rather than base+size so a window touching 2^32 cannot wrap.
  function automatic logic in_window(input logic [SRAM_AW-1:0] addr,
                                     input logic [SRAM_AW-1:0] base,
                                     input logic [SRAM_AW:0]   win_bytes);
    logic [SRAM_AW-1:0] off;
    off = addr - base;
    return (addr >= base) && ({1'b0, off} < win_bytes);
  endfunction

endpackage

// File: rtl/inst_sram_resp_if.sv
// SRAM-style request/response bus between a core fetch/data port and its RAM.
// Handshake: no valid/ready; a request is en=1 on a posedge, read data appears after one edge and is held.
interface inst_sram_resp_if;
  import inst_sram_resp_pkg::*;

  logic                 en;
  logic [SRAM_BE_W-1:0] we;
  logic [SRAM_AW-1:0]   addr;
  logic [SRAM_DW-1:0]   wdata;
  logic [SRAM_DW-1:0]   rdata;

  modport master (output en, output we, output addr, output wdata, input rdata);
  modport slave  (input en, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/inst_sram_resp_sram_byte_lane.sv
// One byte column of the word RAM: DEPTH x 8 with a master write port and a preload write port.
// Read is asynchronous on the master index; the top registers it, which gives read-first ordering.
module sram_byte_lane #(
  parameter int DEPTH_LOG2 = 16
) (
  input  logic                  clk,
  input  logic                  m_we_i,
  input  logic [DEPTH_LOG2-1:0] m_idx_i,
  input  logic [7:0]            m_data_i,
  input  logic                  l_we_i,
  input  logic [DEPTH_LOG2-1:0] l_idx_i,
  input  logic [7:0]            l_data_i,
  output logic [7:0]            r_data_o
);

  logic [7:0] mem_q [2**DEPTH_LOG2];

  // Preload is written last so it wins when both ports hit the same word.
  always_ff @(posedge clk) begin
    if (m_we_i) mem_q[m_idx_i] <= m_data_i;
    if (l_we_i) mem_q[l_idx_i] <= l_data_i;
  end

  assign r_data_o = mem_q[m_idx_i];

endmodule

// File: rtl/inst_sram_resp.sv
// Responder end of an SRAM-style fetch/data port: byte-enable word RAM, 1-cycle read, held rdata,
// sticky out-of-window error and preload port. Request counters exist only with INST_SRAM_STAT_EN.
module inst_sram_resp
  import inst_sram_resp_pkg::*;
#(
  parameter logic [SRAM_AW-1:0] BASE_ADDR  = SRAM_BASE,
  parameter int                 DEPTH_LOG2 = 16,
  parameter string              INIT_FILE  = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  inst_sram_resp_if.slave      sram,
  input  logic                 load_en,
  input  logic [SRAM_AW-1:0]   load_addr,
  input  logic [SRAM_DW-1:0]   load_data,
  output logic                 sram_err,
  output logic [31:0]          stat_rd,
  output logic [31:0]          stat_wr
);

  localparam logic [SRAM_AW:0] WIN_BYTES = (SRAM_AW+1)'(1) << (DEPTH_LOG2 + 2);

  // Boot images arrive through the preload port; file initialisation is not supported here.
  if (INIT_FILE != "") begin : g_init_file_unsupported
    $error("inst_sram_resp: INIT_FILE is not supported, use the preload port");
  end

  acc_kind_e             m_kind;
  logic                  m_hit;
  logic                  l_req;
  logic                  l_hit;
  logic [SRAM_AW-1:0]    m_off;
  logic [SRAM_AW-1:0]    l_off;
  logic [DEPTH_LOG2-1:0] m_idx;
  logic [DEPTH_LOG2-1:0] l_idx;
  logic [SRAM_DW-1:0]    rd_word;
  logic [SRAM_DW-1:0]    rdata_d, rdata_q;
  logic                  err_d, err_q;

  assign m_off = sram.addr - BASE_ADDR;
  assign l_off = load_addr - BASE_ADDR;
  assign m_idx = DEPTH_LOG2'(m_off >> 2);
  assign l_idx = DEPTH_LOG2'(l_off >> 2);
  assign m_hit = in_window(sram.addr, BASE_ADDR, WIN_BYTES);
  assign l_hit = in_window(load_addr, BASE_ADDR, WIN_BYTES);
  assign l_req = load_en && !reset;

  always_comb begin
    m_kind = ACC_IDLE;
    if (!reset && sram.en) m_kind = (sram.we == '0) ? ACC_READ : ACC_WRITE;
  end

  for (genvar i = 0; i < SRAM_BE_W; i++) begin : g_lane
    sram_byte_lane #(.DEPTH_LOG2(DEPTH_LOG2)) u_lane (
      .clk      (clk),
      .m_we_i   ((m_kind == ACC_WRITE) && m_hit && sram.we[i]),
      .m_idx_i  (m_idx),
      .m_data_i (sram.wdata[8*i +: 8]),
      .l_we_i   (l_req && l_hit),
      .l_idx_i  (l_idx),
      .l_data_i (load_data[8*i +: 8]),
      .r_data_o (rd_word[8*i +: 8])
    );
  end

  // Idle cycles hold rdata so the fetch stage can stall without re-requesting.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    case (m_kind)
      ACC_READ:  rdata_d = m_hit ? rd_word : '0;
      ACC_WRITE: rdata_d = '0;
      default:   rdata_d = rdata_q;
    endcase
    if ((m_kind != ACC_IDLE) && !m_hit) err_d = 1'b1;
    if (l_req && !l_hit)                err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign sram.rdata = rdata_q;
  assign sram_err   = err_q;

`ifdef INST_SRAM_STAT_EN
  logic [31:0] stat_rd_d, stat_rd_q;
  logic [31:0] stat_wr_d, stat_wr_q;

  always_comb begin
    stat_rd_d = stat_rd_q;
    stat_wr_d = stat_wr_q;
    if (m_kind == ACC_READ)  stat_rd_d = stat_rd_q + 32'd1;
    if (m_kind == ACC_WRITE) stat_wr_d = stat_wr_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else begin
      stat_rd_q <= stat_rd_d;
      stat_wr_q <= stat_wr_d;
    end
  end

  assign stat_rd = stat_rd_q;
  assign stat_wr = stat_wr_q;
`else
  assign stat_rd = 32'h0;
  assign stat_wr = 32'h0;
`endif

endmodule
